// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared register-file constants and round-robin index helper
package regfile_write_arbiter_pkg;
   localparam int REG_WIDTH   = 32;
   localparam int REG_ADDR_W  = 5;
   localparam int ZERO_REG    = 0;
   localparam int NUM_REQ_DEF = 4;
   localparam int CNT_W_DEF   = 16;

   function automatic logic [2:0] wrap_idx(input logic [3:0] s, input logic [3:0] n);
      return (s >= n) ? 3'(s - n) : 3'(s);
   endfunction
endpackage

// File: rtl/regfile_write_arbiter_rr_priority_select.sv
// rr_priority_select: combinational round-robin picker starting the search at ptr
module rr_priority_select
   import regfile_write_arbiter_pkg::*;
#(
   parameter int N = NUM_REQ_DEF
) (
   input  logic [N-1:0] valid,
   input  logic [2:0]   ptr,
   output logic [N-1:0] grant,
   output logic [2:0]   idx,
   output logic         any
);
   logic [2:0] w_j;
   // scan from the farthest slot back to ptr so the nearest valid requester wins
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      w_j   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_j = wrap_idx({1'b0, ptr} + 4'(k), 4'(N));
         if (valid[w_j]) begin
            grant      = '0;
            grant[w_j] = 1'b1;
            idx        = w_j;
            any        = 1'b1;
         end
      end
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register storage write port
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = REG_WIDTH,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      wr_enable,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [WIDTH-1:0]          wr_data,
   output logic [2:0]                wr_id,
   output logic                      drop_zero,
   output logic [CNT_W-1:0]          accept_count
);
   logic [2:0]         r_ptr;
   logic [NUM_REQ-1:0] w_grant;
   logic [2:0]         w_idx;
   logic               w_any;
   logic               w_acc;
   logic               w_zero;
   logic [ADDR_W-1:0]  w_addr;

   rr_priority_select #(.N(NUM_REQ)) u_sel (
      .valid(req_valid),
      .ptr  (r_ptr),
      .grant(w_grant),
      .idx  (w_idx),
      .any  (w_any)
   );

   assign req_ready = (reset || stall) ? '0 : w_grant;
   assign w_acc     = w_any & ~stall & ~reset;
   assign w_addr    = req_addr[w_idx*ADDR_W +: ADDR_W];
   assign w_zero    = (w_addr == ADDR_W'(ZERO_REG));

   // register the winning write and advance priority past the winner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr        <= '0;
         wr_enable    <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         wr_id        <= '0;
         drop_zero    <= 1'b0;
         accept_count <= '0;
      end else begin
         wr_enable <= w_acc & ~w_zero;
         drop_zero <= w_acc & w_zero;
         if (w_acc) begin
            r_ptr        <= wrap_idx({1'b0, w_idx} + 4'd1, 4'(NUM_REQ));
            wr_addr      <= w_addr;
            wr_data      <= req_data[w_idx*WIDTH +: WIDTH];
            wr_id        <= w_idx;
            accept_count <= accept_count + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard-driven check of grants, writes, stall, zero drop and reset
module tb_regfile_write_arbiter;
   logic         clk = 0;
   logic         reset = 1;
   logic         stall = 0;
   logic [3:0]   req_valid = 0;
   logic [19:0]  req_addr = 0;
   logic [127:0] req_data = 0;
   logic [3:0]   req_ready, req_ready4;
   logic         wr_enable, wr_enable4, drop_zero, drop_zero4;
   logic [4:0]   wr_addr, wr_addr4;
   logic [31:0]  wr_data, wr_data4;
   logic [2:0]   wr_id, wr_id4;
   logic [15:0]  accept_count;
   logic [3:0]   accept_count4;

   typedef struct packed {
      logic        en;
      logic [4:0]  a;
      logic [31:0] d;
      logic [2:0]  id;
      logic        dz;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t e;
   exp_t m_last;
   int   m_ptr = 0;
   int   m_cnt = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid),
      .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .wr_id(wr_id),
      .drop_zero(drop_zero), .accept_count(accept_count)
   );

   regfile_write_arbiter #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid),
      .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready4),
      .wr_enable(wr_enable4), .wr_addr(wr_addr4), .wr_data(wr_data4), .wr_id(wr_id4),
      .drop_zero(drop_zero4), .accept_count(accept_count4)
   );

   function automatic int mwin(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] mready(input logic [3:0] v, input int p);
      int w;
      w = (reset || stall) ? -1 : mwin(v, p);
      return (w < 0) ? 4'b0 : 4'(1 << w);
   endfunction

   task automatic model_reset();
      m_ptr  = 0;
      m_cnt  = 0;
      m_last = '0;
      q.delete();
   endtask

   task automatic tick();
      int w;
      w = (reset || stall) ? -1 : mwin(req_valid, m_ptr);
      @(posedge clk);
      #1;
      if (w >= 0) begin
         m_cnt       = m_cnt + 1;
         m_last.a    = req_addr[w*5 +: 5];
         m_last.d    = req_data[w*32 +: 32];
         m_last.id   = 3'(w);
         m_last.en   = (m_last.a != 0);
         m_last.dz   = (m_last.a == 0);
         m_last.cnt  = 16'(m_cnt);
         m_ptr       = (w + 1) % 4;
      end else begin
         m_last.en = 0;
         m_last.dz = 0;
      end
      q.push_back(m_last);
   endtask

   task automatic do_reset();
      #2 reset = 1;
      #3 reset = 0;
      model_reset();
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      #2;
      checks++;
      if ({wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== 58'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count});
      end
      checks++;
      if (req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=0000", req_ready);
      end
      #8 reset = 0;
      req_valid = 0;
      model_reset();
   endtask

   task automatic test_single();
      req_valid = 4'b0001;
      req_addr[4:0] = 5;
      req_data[31:0] = 88;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_ready got=%b exp=0001", req_ready);
      end
      tick();
      req_valid = 0;
      e = q.pop_front();
      checks++;
      if ({wr_enable, wr_addr, wr_data, wr_id, accept_count} !== {1'b1, 5'd5, 32'd88, 3'd0, 16'd1} ||
          {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
         failures++;
         $display("FAIL single_write got=%h exp=%h", {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
      end
      tick();
      e = q.pop_front();
      checks++;
      if (wr_enable !== 1'b0 || {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
         failures++;
         $display("FAIL single_idle got=%h exp=%h", {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
      end
   endtask

   task automatic test_rotate();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_addr[i*5 +: 5]   = 5'(i + 1);
         req_data[i*32 +: 32] = 32'(10 + i);
      end
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if (req_ready !== 4'(1 << (i % 4))) begin
            failures++;
            $display("FAIL rotate_ready[%0d] got=%b exp=%b", i, req_ready, 4'(1 << (i % 4)));
         end
         tick();
         e = q.pop_front();
         checks++;
         if (wr_data !== 32'(10 + i % 4) || wr_id !== 3'(i % 4) ||
             {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
            failures++;
            $display("FAIL rotate_write[%0d] got=%h exp=%h", i, {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
         end
      end
      req_valid = 0;
      checks++;
      if (accept_count !== 16'd8) begin
         failures++;
         $display("FAIL rotate_count got=%0d exp=8", accept_count);
      end
   endtask

   task automatic test_stall();
      do_reset();
      req_valid = 4'b0001;
      tick();
      void'(q.pop_front());
      stall = 1;
      req_valid = 4'b0110;
      #1;
      checks++;
      if (wr_enable !== 1'b1 || wr_id !== 3'd0) begin
         failures++;
         $display("FAIL stall_inflight got=%b/%0d exp=1/0", wr_enable, wr_id);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (req_ready !== mready(req_valid, m_ptr) || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL stall_ready[%0d] got=%b exp=0000", i, req_ready);
         end
         tick();
         e = q.pop_front();
         checks++;
         if ({wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
            failures++;
            $display("FAIL stall_hold[%0d] got=%h exp=%h", i, {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
         end
         #1;
      end
      stall = 0;
      for (int i = 1; i <= 2; i++) begin
         #1;
         checks++;
         if (req_ready !== 4'(1 << i)) begin
            failures++;
            $display("FAIL stall_release_ready[%0d] got=%b exp=%b", i, req_ready, 4'(1 << i));
         end
         tick();
         req_valid[i] = 0;
         e = q.pop_front();
         checks++;
         if (wr_id !== 3'(i) || {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
            failures++;
            $display("FAIL stall_release_write[%0d] got=%h exp=%h", i, {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
         end
      end
   endtask

   task automatic test_zero();
      req_addr[14:10]  = 0;
      req_data[95:64]  = 89;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL zero_ready got=%b exp=0100", req_ready);
      end
      tick();
      req_valid = 0;
      e = q.pop_front();
      checks++;
      if (wr_enable !== 1'b0 || drop_zero !== 1'b1 || wr_id !== 3'd2 ||
          {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
         failures++;
         $display("FAIL zero_write got=%h exp=%h", {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
      end
      tick();
      e = q.pop_front();
      checks++;
      if (drop_zero !== 1'b0 || {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
         failures++;
         $display("FAIL zero_pulse got=%h exp=%h", {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
      end
   endtask

   task automatic test_async_reset();
      req_addr[9:5] = 7;
      req_valid = 4'b0010;
      tick();
      req_valid = 0;
      #2 reset = 1;
      #1;
      checks++;
      if (wr_enable !== 1'b0 || accept_count !== 16'd0 || drop_zero !== 1'b0) begin
         failures++;
         $display("FAIL async_clear got=%b/%0d/%b exp=0/0/0", wr_enable, accept_count, drop_zero);
      end
      model_reset();
      req_valid = 4'b0001;
      @(posedge clk);
      #2;
      checks++;
      if (accept_count !== 16'd0 || wr_enable !== 1'b0) begin
         failures++;
         $display("FAIL reset_edge_handshake got=%0d/%b exp=0/0", accept_count, wr_enable);
      end
      reset = 0;
      req_valid = 4'b1000;
      req_addr[19:15] = 9;
      req_data[127:96] = 33;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL post_reset_ready got=%b exp=1000", req_ready);
      end
      tick();
      e = q.pop_front();
      checks++;
      if ({wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
         failures++;
         $display("FAIL post_reset_write got=%h exp=%h", {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
      end
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL post_reset_ptr got=%b exp=0001", req_ready);
      end
      req_valid = 0;
   endtask

   task automatic test_wrap();
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 17; i++) begin
         tick();
         e = q.pop_front();
         checks++;
         if ({wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count} !== e) begin
            failures++;
            $display("FAIL wrap_write[%0d] got=%h exp=%h", i, {wr_enable, wr_addr, wr_data, wr_id, drop_zero, accept_count}, e);
         end
      end
      req_valid = 0;
      checks++;
      if (accept_count4 !== 4'd1 || accept_count4 !== 4'(m_cnt)) begin
         failures++;
         $display("FAIL wrap_count4 got=%0d exp=1", accept_count4);
      end
      checks++;
      if (accept_count !== 16'd17) begin
         failures++;
         $display("FAIL wrap_count16 got=%0d exp=17", accept_count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotate();
      test_stall();
      test_zero();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
